uart_tx: RTL and testbench

Transmit half of the course UART: accepts a parallel byte on a single-cycle load strobe and serialises it onto `TX` as an asynchronous frame (start, 7 or 8 data bits LSB first, optional parity, stop fill). It uses the same `baud_value`/`EIGHT`/`PEN`/`OHEL` configuration as the receive path, so the two halves interoperate over a loopback or an external link. `TXRDY` reports buffer-empty to the processor/TSI side, which writes `out_port` with `load`.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_if.sv | 21 ++
 rtl/uart_bit_timer.sv | 27 ++
 rtl/uart_tx.sv | 108 ++++++++++
 tb/tb_uart_tx.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: baud divisor table (100 MHz clock), frame length
// and transmit FSM state encoding.
package uart_pkg;

  localparam int FRAME_LEN = 11;
  localparam int DIV_W     = 19;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tx_state_t;

  // Unlisted selects fall back to the 115200-ish default of 868 cycles.
  function automatic logic [DIV_W-1:0] baud_divisor(input logic [3:0] sel);
    case (sel)
      4'd0:    return 19'd333333;
      4'd1:    return 19'd83333;
      4'd2:    return 19'd41667;
      4'd3:    return 19'd20833;
      4'd4:    return 19'd10417;
      4'd5:    return 19'd5208;
      4'd6:    return 19'd2604;
      4'd7:    return 19'd1736;
      4'd8:    return 19'd868;
      4'd9:    return 19'd434;
      4'd10:   return 19'd217;
      4'd11:   return 19'd109;
      default: return 19'd868;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Processor-side write port of the UART transmitter: byte, load strobe and
// buffer-empty flag.
interface uart_tx_if;

  logic       load;
  logic [7:0] out_port;
  logic       TXRDY;

  modport master (
    output load,
    output out_port,
    input  TXRDY
  );

  modport slave (
    input  load,
    input  out_port,
    output TXRDY
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts clocks while run is high and pulses BTU on the
// last cycle of each bit, then restarts from zero.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [DIV_W-1:0] divisor,
  output logic             BTU
);

  logic [DIV_W-1:0] count;

  assign BTU = run && (count == divisor - DIV_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (!run || BTU) begin
      count <= '0;
    end else begin
      count <= count + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: captures a byte and line configuration on load, then
// shifts out an 11-bit-time frame (start, 7/8 data LSB first, parity, stop fill).
module uart_tx
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] baud_value,
  input  logic       EIGHT,
  input  logic       PEN,
  input  logic       OHEL,
  uart_tx_if.slave   host,
  output logic       TX
);

  tx_state_t              state;
  logic                   txrdy;
  logic                   busy;
  logic [CNT_W-1:0]       bit_cnt;
  logic [FRAME_LEN-1:0]   shift_q;
  logic                   btu;

  logic [7:0]             data_q;
  logic                   eight_q;
  logic                   pen_q;
  logic                   ohel_q;
  logic [DIV_W-1:0]       divisor_q;

  function automatic logic parity_bit(input logic [7:0] d, input logic eight,
                                      input logic odd);
    return (^d[6:0]) ^ (eight & d[7]) ^ odd;
  endfunction

  // Unused frame slots default to 1 so they read as extra stop bits.
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] d,
                                                       input logic eight,
                                                       input logic pen,
                                                       input logic odd);
    logic par;
    logic p8;
    logic p9;
    par = parity_bit(d, eight, odd);
    p8  = eight ? d[7] : (pen ? par : 1'b1);
    p9  = (eight && pen) ? par : 1'b1;
    return {1'b1, p9, p8, d[6:0], 1'b0};
  endfunction

  assign TX         = shift_q[0];
  assign host.TXRDY = txrdy;

  // Byte and line settings are frozen for the whole frame at the accepted load.
  always_ff @(posedge clk) begin
    if (state == IDLE && txrdy && host.load) begin
      data_q    <= host.out_port;
      eight_q   <= EIGHT;
      pen_q     <= PEN;
      ohel_q    <= OHEL;
      divisor_q <= baud_divisor(baud_value);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      txrdy   <= 1'b1;
      busy    <= 1'b0;
      bit_cnt <= '0;
      shift_q <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (host.load && txrdy) begin
            state <= LOAD;
            txrdy <= 1'b0;
          end
        end
        LOAD: begin
          shift_q <= build_frame(data_q, eight_q, pen_q, ohel_q);
          busy    <= 1'b1;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (btu) begin
            shift_q <= {1'b1, shift_q[FRAME_LEN-1:1]};
            if (bit_cnt == CNT_W'(FRAME_LEN - 1)) begin
              bit_cnt <= '0;
              busy    <= 1'b0;
              txrdy   <= 1'b1;
              state   <= IDLE;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_bit_timer u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (busy),
    .divisor (divisor_q),
    .BTU     (btu)
  );

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: random and directed frames compared bit by
// bit against a frame model built from the line rules.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] baud_value = 4'd11;
  logic       eight = 1'b1;
  logic       pen = 1'b0;
  logic       ohel = 1'b0;
  logic       tx;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_if bus ();

  uart_tx dut (
    .clk        (clk),
    .reset      (reset),
    .baud_value (baud_value),
    .EIGHT      (eight),
    .PEN        (pen),
    .OHEL       (ohel),
    .host       (bus),
    .TX         (tx)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_div(input logic [3:0] bv);
    int table_v [12] = '{333333, 83333, 41667, 20833, 10417, 5208,
                         2604, 1736, 868, 434, 217, 109};
    if (bv >= 4'd12) return 868;
    return table_v[bv];
  endfunction

  // Line bits in transmission order: start, data, optional parity, ones to 11.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input bit e,
                                              input bit p, input bit o);
    bit q[$];
    int nb;
    int ones;
    logic [10:0] r;
    nb   = e ? 8 : 7;
    ones = 0;
    q.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      q.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (p) q.push_back(bit'((ones + int'(o)) % 2));
    while (q.size() < 11) q.push_back(1'b1);
    for (int i = 0; i < 11; i++) r[i] = q[i];
    return r;
  endfunction

  // mode 0: clean; 1: stray 0x55 load and config change mid-frame;
  // 2: as 1 but load then stays high to the end of the frame.
  task automatic run_frame(input logic [7:0] d, input bit e, input bit p, input bit o,
                           input logic [3:0] bv, input int mode);
    logic [10:0] bits;
    int dv;
    int ready_hi;
    int mid;
    bits = model_frame(d, e, p, o);
    dv   = ref_div(bv);
    mid  = 3 * dv + dv / 2;
    chk("ready_before_load", 32'(bus.TXRDY), 32'd1);
    bus.out_port = d;
    eight        = e;
    pen          = p;
    ohel         = o;
    baud_value   = bv;
    bus.load     = 1'b1;
    @(negedge clk);
    if (mode != 2) bus.load = 1'b0;
    chk("ready_drop", 32'(bus.TXRDY), 32'd0);
    ready_hi = 0;
    for (int c = 0; c < 11 * dv; c++) begin
      @(negedge clk);
      if (bus.TXRDY) ready_hi++;
      if ((c % dv) == 0 || (c % dv) == dv - 1)
        chk($sformatf("tx_bit%0d_%s_d%0h", c / dv, ((c % dv) == 0) ? "first" : "last", d),
            32'(tx), 32'(bits[c / dv]));
      if (mode != 0 && c == mid) begin
        bus.out_port = 8'h55;
        eight        = 1'($urandom);
        pen          = 1'($urandom);
        ohel         = 1'($urandom);
        baud_value   = 4'd8;
        bus.load     = 1'b1;
      end else if (mode == 1 && c == mid + 1) begin
        bus.load = 1'b0;
      end
    end
    chk("ready_high_in_frame", 32'(ready_hi), 32'd0);
    @(negedge clk);
    chk("ready_after_frame", 32'(bus.TXRDY), 32'd1);
    chk("tx_after_frame", 32'(tx), 32'd1);
  endtask

  initial begin
    logic [10:0] rbits;
    bus.load     = 1'b0;
    bus.out_port = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_hold_tx", 32'(tx), 32'd1);
    chk("rst_hold_ready", 32'(bus.TXRDY), 32'd1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);

    run_frame(8'hAE, 1, 0, 0, 4'd11, 0);
    run_frame(8'hAE, 1, 1, 0, 4'd11, 0);
    run_frame(8'hAE, 1, 1, 1, 4'd11, 0);
    run_frame(8'hAE, 0, 1, 0, 4'd11, 0);

    // Ignored stray load followed by back-to-back reloads.
    run_frame(8'hA3, 1, 1, 1, 4'd11, 1);
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd11, 2);
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd11, 0);

    // Mid-frame baud change must not affect the running frame.
    run_frame(8'($urandom), 1, 0, 0, 4'd11, 1);
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd8, 0);
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd12, 0);
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd15, 0);
    run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd10, 0);

    for (int k = 0; k < 6; k++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'd11,
                int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset in the middle of a frame.
    rbits        = model_frame(8'hC3, 1, 1, 0);
    bus.out_port = 8'hC3;
    eight        = 1'b1;
    pen          = 1'b1;
    ohel         = 1'b0;
    baud_value   = 4'd11;
    bus.load     = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    repeat (400) @(negedge clk);
    chk("pre_rst_tx", 32'(tx), 32'(rbits[3]));
    #2 reset = 1'b0;
    #1;
    chk("async_rst_tx", 32'(tx), 32'd1);
    chk("async_rst_ready", 32'(bus.TXRDY), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_release_tx", 32'(tx), 32'd1);
    run_frame(8'h3C, 1, 1, 1, 4'd11, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
